// File: rtl/hilo_muldiv_seq_if.sv
// rtl/hilo_muldiv_seq_if.sv - request/result bundle between execute stage and the HI/LO unit

interface hilo_muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             flush;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // Execute stage / hazard unit side
    modport master (
        output start, op, x, y, flush,
        input  busy, done, div_by_zero, hi, lo
    );

    // HI/LO unit side
    modport slave (
        input  start, op, x, y, flush,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/hilo_muldiv_seq.sv
// rtl/hilo_muldiv_seq.sv - sequential HI/LO unit: registered multiply, restoring divide, MTHI/MTLO

module hilo_muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    hilo_muldiv_seq_if.slave   bus
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic done_q, done_d;
    logic dbz_q, dbz_d;
    logic busy;

    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH-1:0] mul_a_q, mul_b_q;
    logic             mul_signed_q;

    logic [WIDTH-1:0] quo_q;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH:0]   dvs_q;
    logic [CW-1:0]    cnt_q;
    logic             neg_quo_q;
    logic             neg_rem_q;

    // Request decode; a start is only honoured when idle and not squashed
    logic accept, op_mul, op_div, y_zero;
    assign accept = bus.start && !bus.flush && (state_q == S_IDLE);
    assign op_mul = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
    assign op_div = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
    assign y_zero = (bus.y == '0);

    // Magnitudes carry one extra bit so that |most-negative| is representable
    logic             x_neg, y_neg;
    logic [WIDTH:0]   x_ext, y_ext, x_mag, y_mag;
    assign x_neg = (bus.op == OP_DIV) && bus.x[WIDTH-1];
    assign y_neg = (bus.op == OP_DIV) && bus.y[WIDTH-1];
    assign x_ext = {x_neg, bus.x};
    assign y_ext = {y_neg, bus.y};
    assign x_mag = x_neg ? -x_ext : x_ext;
    assign y_mag = y_neg ? -y_ext : y_ext;

    // Full-width product: extend both operands to 2*WIDTH, keep the low half
    logic [2*WIDTH-1:0] mul_a_ext, mul_b_ext, product;
    assign mul_a_ext = {{WIDTH{mul_signed_q & mul_a_q[WIDTH-1]}}, mul_a_q};
    assign mul_b_ext = {{WIDTH{mul_signed_q & mul_b_q[WIDTH-1]}}, mul_b_q};
    assign product   = mul_a_ext * mul_b_ext;

    // One restoring step: shift in the next dividend bit, subtract if it fits
    logic [WIDTH+1:0] rem_shift, rem_diff;
    logic [WIDTH:0]   rem_n;
    logic [WIDTH-1:0] quo_n;
    assign rem_shift = {rem_q, quo_q[WIDTH-1]};
    assign rem_diff  = rem_shift - {1'b0, dvs_q};
    assign rem_n     = rem_diff[WIDTH+1] ? rem_shift[WIDTH:0] : rem_diff[WIDTH:0];
    assign quo_n     = {quo_q[WIDTH-2:0], ~rem_diff[WIDTH+1]};

    // Sign correction applied in the final cycle of a divide
    logic [WIDTH-1:0] quo_fix, rem_fix;
    assign quo_fix = neg_quo_q ? -quo_q : quo_q;
    assign rem_fix = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

    // State register plus the registered done/div_by_zero pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    // Next-state logic; flush returns to idle from anywhere
    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept && op_mul) begin
                        state_d = S_MUL;
                    end else if (accept && op_div && !y_zero) begin
                        state_d = S_DIV;
                    end
                end
                S_MUL:   state_d = S_IDLE;
                S_DIV:   state_d = (cnt_q == '0) ? S_FIX : S_DIV;
                S_FIX:   state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs: busy from state, done pulse on the edge that writes hi/lo
    always_comb begin
        busy   = (state_q != S_IDLE);
        done_d = 1'b0;
        dbz_d  = 1'b0;
        if (!bus.flush) begin
            case (state_q)
                S_IDLE: begin
                    if (accept && op_div && y_zero) begin
                        done_d = 1'b1;
                        dbz_d  = 1'b1;
                    end
                end
                S_MUL, S_FIX: done_d = 1'b1;
                default:      done_d = 1'b0;
            endcase
        end
    end

    // HI/LO write selection; a squashed op never touches the architectural pair
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (!bus.flush) begin
            case (state_q)
                S_IDLE: begin
                    if (accept && (bus.op == OP_MTHI)) hi_d = bus.x;
                    if (accept && (bus.op == OP_MTLO)) lo_d = bus.x;
                end
                S_MUL: {hi_d, lo_d} = product;
                S_FIX: begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
                default: begin
                    hi_d = hi_q;
                    lo_d = lo_q;
                end
            endcase
        end
    end

    // Architectural HI/LO registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    // Operand capture and divider iteration
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            mul_signed_q <= 1'b0;
            quo_q        <= '0;
            rem_q        <= '0;
            dvs_q        <= '0;
            cnt_q        <= '0;
            neg_quo_q    <= 1'b0;
            neg_rem_q    <= 1'b0;
        end else begin
            if (accept && op_mul) begin
                mul_a_q      <= bus.x;
                mul_b_q      <= bus.y;
                mul_signed_q <= (bus.op == OP_MULT);
            end
            if (accept && op_div && !y_zero) begin
                // The dividend magnitude's top bit is always clear, so seeding
                // the partial remainder with it is the same as clearing it.
                quo_q     <= x_mag[WIDTH-1:0];
                rem_q     <= {x_mag[WIDTH], {WIDTH{1'b0}}};
                dvs_q     <= y_mag;
                cnt_q     <= CW'(WIDTH - 1);
                neg_quo_q <= x_neg ^ y_neg;
                neg_rem_q <= x_neg;
            end else if (state_q == S_DIV) begin
                quo_q <= quo_n;
                rem_q <= rem_n;
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end
        end
    end

    assign bus.busy        = busy;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_seq.sv
// tb/tb_hilo_muldiv_seq.sv - self-checking bench for hilo_muldiv_seq

module tb_hilo_muldiv_seq;

    localparam int W = 32;

    localparam logic [2:0] NOP   = 3'd0;
    localparam logic [2:0] MULT  = 3'd1;
    localparam logic [2:0] MULTU = 3'd2;
    localparam logic [2:0] DIV   = 3'd3;
    localparam logic [2:0] DIVU  = 3'd4;
    localparam logic [2:0] MTHI  = 3'd5;
    localparam logic [2:0] MTLO  = 3'd6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hilo_muldiv_seq_if #(.WIDTH(W)) bus();

    hilo_muldiv_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference arithmetic: returns {hi, lo}
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint     sa, sb, q, r;
        logic [31:0] uq, ur;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = '0;
        case (op)
            MULT:  p = 64'(sa * sb);
            MULTU: p = {32'b0, a} * {32'b0, b};
            DIV: begin
                q = sa / sb;
                r = sa % sb;
                p = {r[31:0], q[31:0]};
            end
            DIVU: begin
                uq = a / b;
                ur = a % b;
                p  = {ur, uq};
            end
            default: p = '0;
        endcase
        return p;
    endfunction

    // Behavioural model: a countdown of busy cycles and a pending result
    int          m_left = 0;
    logic [31:0] m_hi = '0, m_lo = '0, r_hi = '0, r_lo = '0;
    bit          m_done = 1'b0, m_dbz = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left = 0; m_hi = '0; m_lo = '0; m_done = 1'b0; m_dbz = 1'b0;
        end else begin
            m_done = 1'b0;
            m_dbz  = 1'b0;
            if (bus.flush) begin
                m_left = 0;
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_hi = r_hi; m_lo = r_lo; m_done = 1'b1;
                end
            end else if (bus.start) begin
                case (bus.op)
                    MTHI: m_hi = bus.x;
                    MTLO: m_lo = bus.x;
                    MULT, MULTU: begin
                        {r_hi, r_lo} = ref_result(bus.op, bus.x, bus.y);
                        m_left = 1;
                    end
                    DIV, DIVU: begin
                        if (bus.y == '0) begin
                            m_done = 1'b1; m_dbz = 1'b1;
                        end else begin
                            {r_hi, r_lo} = ref_result(bus.op, bus.x, bus.y);
                            m_left = W + 1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 64'(bus.busy), 64'(m_left > 0));
            chk("done", 64'(bus.done), 64'(m_done));
            chk("div_by_zero", 64'(bus.div_by_zero), 64'(m_dbz));
            chk("hi", 64'(bus.hi), 64'(m_hi));
            chk("lo", 64'(bus.lo), 64'(m_lo));
        end
    end

    // Present a one-cycle start; called and returns just after a rising edge
    task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        bus.start = 1'b1; bus.op = op; bus.x = x; bus.y = y;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.op = NOP;
    endtask

    // Wait (bounded) for done, then check latency and the literal results
    task automatic run_wait(input string name, input int exp_lat, input logic [31:0] ehi,
                            input logic [31:0] elo, input bit edbz);
        int n    = 0;
        bit seen = 1'b0;
        while (n < 60 && !seen) begin
            @(negedge clk);
            n++;
            if (bus.done) seen = 1'b1;
        end
        chk({name, " latency"}, 64'(n), 64'(exp_lat));
        chk({name, " hi"}, 64'(bus.hi), 64'(ehi));
        chk({name, " lo"}, 64'(bus.lo), 64'(elo));
        chk({name, " dbz"}, 64'(bus.div_by_zero), 64'(edbz));
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0; bus.op = NOP; bus.x = '0; bus.y = '0; bus.flush = 1'b0;
        repeat (2) @(posedge clk);
        chk_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("reset busy", 64'(bus.busy), 64'd0);
        chk("reset done", 64'(bus.done), 64'd0);
        chk("reset hi", 64'(bus.hi), 64'd0);
        chk("reset lo", 64'(bus.lo), 64'd0);

        // MTHI / MTLO
        issue(MTHI, 32'hDEAD_BEEF, 32'h0);
        chk("mthi", 64'(bus.hi), 64'h0000_0000_DEAD_BEEF);
        issue(MTLO, 32'h1234_5678, 32'h0);
        chk("mtlo", 64'(bus.lo), 64'h0000_0000_1234_5678);
        chk("mtlo keeps hi", 64'(bus.hi), 64'h0000_0000_DEAD_BEEF);

        // Multiply
        issue(MULT, 32'hFFFF_FFFE, 32'd3);
        run_wait("mult", 2, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
        issue(MULTU, 32'hFFFF_FFFE, 32'd3);
        run_wait("multu", 2, 32'h0000_0002, 32'hFFFF_FFFA, 1'b0);

        // Divide
        issue(DIV, 32'hFFFF_FFF9, 32'd2);
        run_wait("div -7/2", 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        issue(DIVU, 32'd100, 32'd7);
        run_wait("divu 100/7", 34, 32'd2, 32'd14, 1'b0);
        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_wait("div overflow", 34, 32'h0, 32'h8000_0000, 1'b0);
        issue(DIVU, 32'd5, 32'd0);
        run_wait("divu by zero", 1, 32'h0, 32'h8000_0000, 1'b1);

        // Flush mid-divide
        issue(MTHI, 32'd1, 32'd0);
        issue(MTLO, 32'd2, 32'd0);
        issue(DIVU, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        chk("flush busy", 64'(bus.busy), 64'd0);
        chk("flush hi", 64'(bus.hi), 64'd1);
        chk("flush lo", 64'(bus.lo), 64'd2);
        repeat (40) @(posedge clk);
        #1;

        // Asynchronous reset mid-divide
        issue(DIVU, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst busy", 64'(bus.busy), 64'd0);
        chk("arst hi", 64'(bus.hi), 64'd0);
        chk("arst lo", 64'(bus.lo), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Start while busy is ignored
        issue(DIVU, 32'd100, 32'd7);
        bus.start = 1'b1; bus.op = MULTU; bus.x = 32'd3; bus.y = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.op = NOP;
        run_wait("start while busy", 33, 32'd2, 32'd14, 1'b0);
        repeat (5) @(posedge clk);
        #1;

        // flush beats start in the same idle cycle
        bus.flush = 1'b1;
        issue(MTHI, 32'h0000_0055, 32'h0);
        bus.flush = 1'b0;
        chk("flush drops mthi", 64'(bus.hi), 64'd2);
        bus.flush = 1'b1;
        issue(MULT, 32'd3, 32'd3);
        bus.flush = 1'b0;
        chk("flush drops mult", 64'(bus.busy), 64'd0);
        repeat (4) @(posedge clk);
        #1;

        // Random operations including corner operands
        for (int i = 0; i < 500; i++) begin
            logic [2:0] op;
            int k;
            op = 3'($urandom_range(0, 7));
            issue(op, pick(), pick());
            k = 0;
            while (bus.busy && k < 50) begin
                @(posedge clk); #1;
                k++;
            end
            chk("random op completes", 64'(bus.busy), 64'd0);
        end
        repeat (3) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
